uart_rx_loader: RTL
===================

Name: uart_rx_loader

Overview:
- Serial-load front end that sits directly upstream of the GPIO register.
- Receives 8N1 UART frames on one pin and converts each valid byte into a write-data byte plus a one-cycle write strobe.
- In the top level, its wdata/we drive the GPIO register's wdata/we, so a host can set the GPIO/PWM/7-seg value over one wire instead of eight parallel pins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 8..65535. Must be even.
- DATA_BITS, 8, payload bits per frame, LSB first. Fixed at 8 for this release.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  receiver enable (tied to ena at top).
- rx  input  1  asynchronous serial line; idle high.
- wdata  output  8  last correctly received byte.
- we  output  1  one-cycle strobe; wdata is valid in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wdata=8'h00, we=0, frame_err=0, busy=0.
  - FSM goes to IDLE; bit counter and bit index are cleared.
  - Synchronizer flops are set to 1.
  - Reset mid-frame aborts the frame with no we and no frame_err.
- Input synchronizer:
  - rx passes through 2 flops; rx_s is the second flop. All decisions use rx_s.
- Counters:
  - cnt is $clog2(CLKS_PER_BIT) bits wide. bit_idx is 3 bits.
  - Whenever cnt reaches its terminal value it returns to 0.
- FSM states:
  - IDLE: if en=1 and rx_s=0, go to START with cnt=0.
  - START: increment cnt. At cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s=0: go to DATA, cnt=0, bit_idx=0.
    - rx_s=1: glitch; return to IDLE silently.
  - DATA: increment cnt. At cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, LSB first).
    - bit_idx==7: go to STOP.
    - otherwise: increment bit_idx.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: wdata<=shreg, we=1 for exactly one cycle, go to IDLE.
    - rx_s=0: frame_err=1 for one cycle, wdata unchanged, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A line held low (break) produces exactly one frame_err, not repeated errors.
- Latency:
  - Define cycle 0 as the first cycle rx_s=0 in IDLE.
  - we is asserted at cycle CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (center of the stop bit).
  - Measured from the rx pin edge, add 2 cycles for the synchronizer.
- Back-to-back frames:
  - IDLE is re-entered the cycle after we, so a start bit beginning at the end of the stop bit is accepted.
  - A receiver with up to ±3% baud mismatch must still receive correctly.
- en deasserted:
  - Blocks new starts in IDLE.
  - If en falls mid-frame, the FSM returns to IDLE next cycle with no we and no frame_err.
- we and frame_err are never high in the same cycle. busy=0 in the cycle we is high.
- wdata holds its value between strobes.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK} (3-bit encoding).
  - localparam for default CLKS_PER_BIT.
  - function computing the counter width.
- Sub-module sync_2ff: generic 2-flop synchronizer with a reset value parameter (reset value 1 here). It is reused later for other async pins.

Test Plan:
- Use CLKS_PER_BIT=16 for all scenarios.
1. Reset then send 0xA5: we pulses once, wdata=8'hA5, frame_err=0, we at cycle 8+144 after rx_s falls (±0 in bench after the sync offset).
2. Two back-to-back frames 0x3C then 0xFF with no idle gap: two we pulses 160 cycles apart, wdata=8'h3C then 8'hFF.
3. A 5-cycle low glitch on idle rx: no we, busy returns to 0 within 9 cycles of the glitch start, wdata unchanged.
4. Frame 0x55 with the stop bit forced low, line then held low 100 cycles: one frame_err pulse, no we, wdata keeps its previous value, FSM reaches IDLE only after rx returns high.
5. en=0 while sending 0x81: no we. Then en dropped mid-frame during bit 4: busy falls next cycle, no we, no frame_err. A subsequent 0x81 with en=1 gives wdata=8'h81.
6. rst asserted during DATA of frame 0x42: all outputs zero next cycle. A following clean 0x42 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART serial-load front end.
// Imported by the receiver top and its sub-blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int CLKS_PER_BIT_DEF = 434;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous input pins.
// Reset value is a parameter so idle-high lines start inactive.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that turns each good byte into a GPIO
// write strobe; stop-bit errors pulse frame_err once per break.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] wdata,
  output logic       we,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      we        <= 1'b0;
      frame_err <= 1'b0;
      // Dropping enable abandons any frame in flight silently.
      if (state != IDLE && !en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (en && !rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == HALF_T) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == FULL_T) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[7:1]};
              if (bit_idx == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == FULL_T) begin
              cnt <= '0;
              if (rx_s) begin
                wdata <= shreg;
                we    <= 1'b1;
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          BREAK: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
